// File: rtl/store_unit.sv
// store_unit: RISC-V style sb/sh/sw store unit with alignment checking and memory handshake
module store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic        done,
  output logic        addr_err,
  output logic [31:0] err_addr,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP, ERR} state_t;
  state_t state, state_next;
  logic [1:0] size_q;
  logic [31:0] addr_q, data_q;
  logic bad, accept;
  always_comb begin
    accept = req_valid & state == IDLE;
    bad = req_size == 2'b11 | (req_size == 2'b01 & req_addr[0]) | (req_size == 2'b10 & req_addr[1:0] != 2'b00);
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_next;
  always_comb
    state_next = state == IDLE ? (accept ? (bad ? ERR : ISSUE) : IDLE) :
                 state == ISSUE ? (mem_ack ? RESP : ISSUE) : IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      size_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      err_addr <= '0;
    end else begin
      if (accept) begin
        size_q <= req_size;
        addr_q <= req_addr;
        data_q <= req_data;
      end
      if (accept & bad) err_addr <= req_addr;
    end
  always_comb begin
    req_ready = state == IDLE;
    busy = state != IDLE;
    mem_en = state == ISSUE;
    done = state == RESP;
    addr_err = state == ERR;
    mem_addr = {addr_q[31:2], 2'b00};
    mem_we = state != ISSUE ? 4'b0000 :
             size_q == 2'b00 ? 4'b0001 << addr_q[1:0] :
             size_q == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    mem_wdata = size_q == 2'b00 ? {4{data_q[7:0]}} :
                size_q == 2'b01 ? {2{data_q[15:0]}} : data_q;
  end
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed self-checking bench for store_unit
module tb_store_unit;
  logic clk = 0, rst = 1, req_valid = 0, mem_ack = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_data = 0;
  logic req_ready, mem_en, done, addr_err, busy;
  logic [3:0] mem_we;
  logic [31:0] mem_addr, mem_wdata, err_addr;
  int tests = 0, fails = 0;

  store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_size(req_size), .req_addr(req_addr), .req_data(req_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .done(done), .addr_err(addr_err), .err_addr(err_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    req_size = s; req_addr = a; req_data = d; req_valid = 1;
    tick;
    req_valid = 0; req_data = 32'hdead_beef; req_addr = 32'hffff_ffff; req_size = 2'b10;
  endtask

  task automatic test_reset;
    rst = 1; req_valid = 1; req_size = 2'b10; req_addr = 32'h40; req_data = 32'h5555_5555;
    tick; tick;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if ({mem_en, mem_we} !== 5'b0) begin fails++; $display("FAIL reset_mem_en_we got %b exp 00000", {mem_en, mem_we}); end
    tests++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin fails++; $display("FAIL reset_addr_wdata got %h %h exp 0 0", mem_addr, mem_wdata); end
    tests++; if ({done, addr_err} !== 2'b0 || err_addr !== 32'h0) begin fails++; $display("FAIL reset_flags got %b %h exp 00 0", {done, addr_err}, err_addr); end
    req_valid = 0; rst = 0;
    tick;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_no_accept busy got %b exp 0", busy); end
  endtask

  task automatic test_sb;
    send(2'b00, 32'h1000_0003, 32'h1234_56ab);
    tests++; if (mem_en !== 1'b1 || mem_addr !== 32'h1000_0000) begin fails++; $display("FAIL sb_issue got en=%b addr=%h exp 1 10000000", mem_en, mem_addr); end
    tests++; if (mem_we !== 4'b1000 || mem_wdata !== 32'habab_abab) begin fails++; $display("FAIL sb_lanes got we=%b wdata=%h exp 1000 abababab", mem_we, mem_wdata); end
    mem_ack = 1;
    tick;
    mem_ack = 0;
    tests++; if ({done, mem_en, mem_we, req_ready} !== 7'b1000000) begin fails++; $display("FAIL sb_done got done/en/we/ready=%b exp 1000000", {done, mem_en, mem_we, req_ready}); end
    tick;
    tests++; if ({done, req_ready, busy} !== 3'b010) begin fails++; $display("FAIL sb_idle got done/ready/busy=%b exp 010", {done, req_ready, busy}); end
  endtask

  task automatic test_sh_wait;
    send(2'b01, 32'h0000_0042, 32'hffff_beef);
    for (int i = 0; i < 4; i++) begin
      mem_ack = i == 3;
      req_data = 32'h0101_0101 * i;
      tests++; if ({mem_en, busy, mem_we} !== 6'b111100 || mem_wdata !== 32'hbeef_beef || mem_addr !== 32'h40) begin fails++; $display("FAIL sh_hold[%0d] got en/busy/we=%b wdata=%h addr=%h exp 111100 beefbeef 40", i, {mem_en, busy, mem_we}, mem_wdata, mem_addr); end
      tick;
    end
    mem_ack = 0;
    tests++; if ({done, busy, mem_en} !== 3'b110) begin fails++; $display("FAIL sh_done got done/busy/en=%b exp 110", {done, busy, mem_en}); end
    tick;
    tests++; if ({done, req_ready} !== 2'b01) begin fails++; $display("FAIL sh_idle got done/ready=%b exp 01", {done, req_ready}); end
  endtask

  task automatic test_err(input logic [1:0] s, input logic [31:0] a);
    send(s, a, 32'h0bad_f00d);
    mem_ack = 1;
    tests++; if ({addr_err, done, mem_en, mem_we} !== 7'b1000000 || err_addr !== a) begin fails++; $display("FAIL err_pulse size=%b got err/done/en/we=%b err_addr=%h exp 1000000 %h", s, {addr_err, done, mem_en, mem_we}, err_addr, a); end
    tick;
    mem_ack = 0;
    tests++; if ({addr_err, done, req_ready} !== 3'b001 || err_addr !== a) begin fails++; $display("FAIL err_after size=%b got err/done/ready=%b err_addr=%h exp 001 %h", s, {addr_err, done, req_ready}, err_addr, a); end
  endtask

  task automatic test_rst_mid_issue;
    send(2'b10, 32'h0000_0020, 32'hcafe_f00d);
    tests++; if (mem_en !== 1'b1 || mem_we !== 4'b1111 || mem_wdata !== 32'hcafe_f00d) begin fails++; $display("FAIL rst_mid_issue got en=%b we=%b wdata=%h exp 1 1111 cafef00d", mem_en, mem_we, mem_wdata); end
    tick;
    rst = 1; mem_ack = 1;
    tick;
    rst = 0;
    tests++; if ({mem_en, done, req_ready, busy} !== 4'b0010 || err_addr !== 32'h0) begin fails++; $display("FAIL rst_mid_idle got en/done/ready/busy=%b err_addr=%h exp 0010 0", {mem_en, done, req_ready, busy}, err_addr); end
    for (int i = 0; i < 2; i++) begin
      tick;
      tests++; if ({mem_en, done, req_ready} !== 3'b001) begin fails++; $display("FAIL rst_late_ack[%0d] got en/done/ready=%b exp 001", i, {mem_en, done, req_ready}); end
    end
    mem_ack = 0;
  endtask

  task automatic test_back_to_back;
    req_valid = 1; req_size = 2'b10; req_addr = 32'h100; req_data = 32'h1111_1111; mem_ack = 1;
    tick;
    tests++; if (mem_en !== 1'b1 || mem_wdata !== 32'h1111_1111 || mem_addr !== 32'h100) begin fails++; $display("FAIL b2b_first got en=%b wdata=%h addr=%h exp 1 11111111 100", mem_en, mem_wdata, mem_addr); end
    req_addr = 32'h104; req_data = 32'h2222_2222;
    #1;
    tests++; if (mem_wdata !== 32'h1111_1111 || mem_addr !== 32'h100) begin fails++; $display("FAIL b2b_first_held got wdata=%h addr=%h exp 11111111 100", mem_wdata, mem_addr); end
    tick;
    tests++; if ({done, req_ready} !== 2'b10) begin fails++; $display("FAIL b2b_done1 got done/ready=%b exp 10", {done, req_ready}); end
    tick;
    tests++; if ({done, req_ready} !== 2'b01) begin fails++; $display("FAIL b2b_ready got done/ready=%b exp 01", {done, req_ready}); end
    tick;
    tests++; if (mem_en !== 1'b1 || mem_wdata !== 32'h2222_2222 || mem_addr !== 32'h104) begin fails++; $display("FAIL b2b_second got en=%b wdata=%h addr=%h exp 1 22222222 104", mem_en, mem_wdata, mem_addr); end
    req_valid = 0; req_data = 32'h3333_3333;
    #1;
    tests++; if (mem_wdata !== 32'h2222_2222) begin fails++; $display("FAIL b2b_second_held got %h exp 22222222", mem_wdata); end
    tick;
    mem_ack = 0;
    tests++; if ({done, req_ready} !== 2'b10) begin fails++; $display("FAIL b2b_done2 got done/ready=%b exp 10", {done, req_ready}); end
    tick;
    tests++; if ({done, req_ready, busy} !== 3'b010) begin fails++; $display("FAIL b2b_end got done/ready/busy=%b exp 010", {done, req_ready, busy}); end
  endtask

  initial begin
    test_reset;
    test_sb;
    test_sh_wait;
    test_err(2'b10, 32'h0000_0006);
    test_err(2'b11, 32'h1234_5678);
    test_err(2'b01, 32'h0000_0001);
    test_rst_mid_issue;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
